imem_read_resp: RTL

- Memory-side responder for the IF-stage read port (m_re / addr / m_rlen / m_rack / data).
- Accepts one read request at a time and fetches 1-4 bytes sequentially from a byte-wide synchronous RAM with fixed read latency.
- Assembles the bytes little-endian and returns them with a four-phase acknowledge.
- Sits between the IF stage and the backing instruction/data RAM.

---
 rtl/imem_read_resp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/imem_read_resp.sv
// imem_read_resp: memory-side responder for the IF-stage read port.
// Fetches 1-4 bytes one at a time from a byte-wide synchronous RAM with a
// fixed read latency, packs them little-endian and returns them under a
// four-phase m_re/m_rack handshake. A request whose last byte falls outside
// the RAM is acknowledged with m_err set and no RAM access.
`timescale 1ns/1ps

module imem_read_resp #(
    parameter int MADDR_L = 32,
    parameter int DATA_L  = 32,
    parameter int MEM_AW  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               m_re,
    input  logic [MADDR_L-1:0] addr,
    input  logic [1:0]         m_rlen,
    output logic               m_rack,
    output logic [DATA_L-1:0]  dataout,
    output logic               m_err,
    output logic               ram_re,
    output logic [MEM_AW-1:0]  ram_addr,
    input  logic [7:0]         ram_rdata
);

    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT);
    // Highest legal byte address, widened so the range compare cannot wrap.
    localparam logic [MADDR_L:0] ADDR_LIMIT = {{(MADDR_L + 1 - MEM_AW){1'b0}}, {MEM_AW{1'b1}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ERR   = 3'd3,
        ACK   = 3'd4
    } state_t;

    state_t              state_r;
    logic [MEM_AW-1:0]   base_r;
    logic [1:0]          rlen_r;
    logic [1:0]          idx_r;
    logic [CW-1:0]       cnt_r;
    logic [DATA_L-1:0]   asm_r;
    logic [DATA_L-1:0]   dataout_r;
    logic                m_rack_r;
    logic                m_err_r;
    logic                ram_re_r;
    logic [MEM_AW-1:0]   ram_addr_r;

    logic [MADDR_L:0]    req_end_s;
    logic                range_err_s;
    logic [DATA_L-1:0]   asm_next_s;
    logic [1:0]          idx_inc_s;
    logic [MEM_AW-1:0]   next_addr_s;

    // Range check of the incoming request, byte merge and next byte address.
    always_comb begin
        req_end_s   = {1'b0, addr} + {{(MADDR_L - 1){1'b0}}, m_rlen};
        range_err_s = (req_end_s > ADDR_LIMIT);
        asm_next_s  = asm_r;
        asm_next_s[{idx_r, 3'b000} +: 8] = ram_rdata;
        idx_inc_s   = idx_r + 2'd1;
        next_addr_s = base_r + {{(MEM_AW - 2){1'b0}}, idx_inc_s};
    end

    // Request FSM: accept, issue/wait per byte, acknowledge, release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            base_r     <= {MEM_AW{1'b0}};
            rlen_r     <= 2'd0;
            idx_r      <= 2'd0;
            cnt_r      <= {CW{1'b0}};
            asm_r      <= {DATA_L{1'b0}};
            dataout_r  <= {DATA_L{1'b0}};
            m_rack_r   <= 1'b0;
            m_err_r    <= 1'b0;
            ram_re_r   <= 1'b0;
            ram_addr_r <= {MEM_AW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    ram_re_r <= 1'b0;
                    if (m_re && !m_rack_r) begin
                        base_r <= addr[MEM_AW-1:0];
                        rlen_r <= m_rlen;
                        idx_r  <= 2'd0;
                        asm_r  <= {DATA_L{1'b0}};
                        if (range_err_s) begin
                            state_r <= ERR;
                        end else begin
                            state_r    <= ISSUE;
                            ram_re_r   <= 1'b1;
                            ram_addr_r <= addr[MEM_AW-1:0];
                        end
                    end
                end
                ISSUE: begin
                    // Strobe lasts exactly this one cycle.
                    ram_re_r <= 1'b0;
                    cnt_r    <= CNT_LOAD;
                    state_r  <= WAIT;
                end
                WAIT: begin
                    if (cnt_r == CNT_ONE) begin
                        asm_r <= asm_next_s;
                        if (idx_r == rlen_r) begin
                            dataout_r <= asm_next_s;
                            m_rack_r  <= 1'b1;
                            m_err_r   <= 1'b0;
                            state_r   <= ACK;
                        end else begin
                            idx_r      <= idx_inc_s;
                            ram_addr_r <= next_addr_s;
                            ram_re_r   <= 1'b1;
                            state_r    <= ISSUE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ERR: begin
                    dataout_r <= {DATA_L{1'b0}};
                    m_rack_r  <= 1'b1;
                    m_err_r   <= 1'b1;
                    state_r   <= ACK;
                end
                ACK: begin
                    // Hold the ack until the initiator drops its request.
                    if (!m_re) begin
                        m_rack_r <= 1'b0;
                        m_err_r  <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    ram_re_r <= 1'b0;
                    m_rack_r <= 1'b0;
                    m_err_r  <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign m_rack   = m_rack_r;
    assign m_err    = m_err_r;
    assign dataout  = dataout_r;
    assign ram_re   = ram_re_r;
    assign ram_addr = ram_addr_r;

endmodule
